// File: rtl/inst_queue_pkg.sv
// Shared constants and types for the fetch-to-decode instruction queue.
// The queue entry bundles a PC with its instruction word.
package inst_queue_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] IQ_NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } iq_entry_t;

    localparam int IQ_ENTRY_W = $bits(iq_entry_t);

endpackage

// File: rtl/inst_queue_ram.sv
// Instruction queue storage: one synchronous write port, one async read port.
// No reset on the array; occupancy tracking lives in the parent.
module inst_queue_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: circular buffer with FWFT head output.
// Flush drops all entries; empty queue presents a NOP at PC 0.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] NOP_INST = IQ_NOP_INST,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_inst,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst,
    output logic [AW:0]     count
);

    localparam logic [AW:0] FULL = AW'(0) + (AW+1)'(DEPTH);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic          push;
    logic          pop;
    iq_entry_t     wr_entry;
    iq_entry_t     head;
    logic [IQ_ENTRY_W-1:0] rd_data;

    // Handshake readiness comes from registered occupancy only.
    assign if_ready = (cnt != FULL);
    assign id_valid = (cnt != '0);

    assign push = if_valid & if_ready & ~flush;
    assign pop  = id_valid & id_ready & ~flush;

    assign wr_entry.pc   = if_pc;
    assign wr_entry.inst = if_inst;

    inst_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (IQ_ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wptr),
        .wdata (wr_entry),
        .raddr (rptr),
        .rdata (rd_data)
    );

    assign head    = iq_entry_t'(rd_data);
    assign id_pc   = id_valid ? head.pc : '0;
    assign id_inst = id_valid ? head.inst : NOP_INST;
    assign count   = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios then random traffic
// against a queue-based reference model.
module tb_inst_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    logic [63:0] model_q [$];

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .id_valid (id_valid),
        .id_ready (id_ready),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output with what the model says should be visible now.
    task automatic check_all(input string tag);
        int n;
        n = model_q.size();
        check({tag, ".if_ready"}, 64'(if_ready), 64'(n != DEPTH));
        check({tag, ".id_valid"}, 64'(id_valid), 64'(n != 0));
        check({tag, ".count"}, 64'(count), 64'(n));
        check({tag, ".id_pc"}, 64'(id_pc),
              (n != 0) ? 64'(model_q[0][63:32]) : 64'h0);
        check({tag, ".id_inst"}, 64'(id_inst),
              (n != 0) ? 64'(model_q[0][31:0]) : 64'h13);
    endtask

    // Called at a negedge: check, drive, advance the model, cross one posedge.
    task automatic step(input string tag, input logic iv, input logic [31:0] pc,
                        input logic ir, input logic fl);
        bit rdy;
        bit vld;
        check_all(tag);
        flush    = fl;
        if_valid = iv;
        if_pc    = pc;
        if_inst  = pc ^ 32'hA5A5_0000;
        id_ready = ir;
        rdy = (model_q.size() != DEPTH);
        vld = (model_q.size() != 0);
        if (fl) begin
            model_q.delete();
        end else begin
            if (ir && vld) void'(model_q.pop_front());
            if (iv && rdy) model_q.push_back({pc, pc ^ 32'hA5A5_0000});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        if_valid = 1'b0;
        if_pc    = '0;
        if_inst  = '0;
        id_ready = 1'b0;
        #12;
        check_all("reset_low");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_inst", 64'(id_inst), 64'h0000_0013);
        check("reset_ready", 64'(if_ready), 64'h1);

        // Fill to full, then a refused fifth push, then drain.
        for (int i = 0; i < 5; i++) step("fill", 1'b1, 32'(i * 4), 1'b0, 1'b0);
        check("full_count", 64'(count), 64'd4);
        check("full_ready", 64'(if_ready), 64'h0);
        for (int i = 0; i < 4; i++) begin
            check("drain_pc", 64'(id_pc), 64'(i * 4));
            step("drain", 1'b0, 32'h0, 1'b1, 1'b0);
        end
        check("drained_valid", 64'(id_valid), 64'h0);

        // Streaming: one push and one pop per cycle, pointers wrap.
        for (int i = 0; i < 10; i++) begin
            step("stream", 1'b1, 32'(i * 4), 1'b1, 1'b0);
            check("stream_count", 64'(count), 64'd1);
            check("stream_pc", 64'(id_pc), 64'(i * 4));
        end
        step("stream_end", 1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with a simultaneous push.
        for (int i = 0; i < 3; i++) step("pre_flush", 1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
        step("flush", 1'b1, 32'h40, 1'b0, 1'b1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(id_valid), 64'h0);
        step("post_flush", 1'b1, 32'h80, 1'b0, 1'b0);
        check("post_flush_pc", 64'(id_pc), 64'h80);
        step("post_flush_pop", 1'b0, 32'h0, 1'b1, 1'b0);

        // At full: pop plus attempted push in the same cycle.
        for (int i = 0; i < 4; i++) step("refill", 1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b0);
        step("full_popush", 1'b1, 32'h300, 1'b1, 1'b0);
        check("full_popush_count", 64'(count), 64'd3);
        check("full_popush_ready", 64'(if_ready), 64'h1);
        step("retry_push", 1'b1, 32'h300, 1'b0, 1'b0);
        check("retry_count", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) step("flush_drain", 1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-burst with two entries queued.
        step("burst", 1'b1, 32'h500, 1'b0, 1'b0);
        step("burst", 1'b1, 32'h504, 1'b0, 1'b0);
        if_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 64'(id_valid), 64'h0);
        check("async_count", 64'(count), 64'd0);
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step("after_rst", 1'b1, 32'h600, 1'b0, 1'b0);
        check("after_rst_pc", 64'(id_pc), 64'h600);
        step("after_rst_pop", 1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
        end
        check_all("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
